// File: rtl/i2s_codec_ep.sv
// Codec-side I2S slave endpoint: follows external SCK/WS, deserializes stereo frames onto rx valid/ready and serializes tx frames onto sd_o.
// Optional build macro I2S_CODEC_STAT_EN adds saturating overrun/underrun counters (ovr_cnt_o, udr_cnt_o).
module i2s_codec_ep #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    en_i,
    input  logic                    lsb_i,
    input  logic [1:0]              dtl_i,
    input  logic                    sck_i,
    input  logic                    ws_i,
    input  logic                    sd_i,
    output logic                    sd_o,
    output logic                    rx_valid_o,
    input  logic                    rx_ready_i,
    output logic [2*DATA_WIDTH-1:0] rx_data_o,
    input  logic                    tx_valid_i,
    output logic                    tx_ready_o,
    input  logic [2*DATA_WIDTH-1:0] tx_data_i,
    output logic                    ovr_o,
    output logic                    udr_o,
`ifdef I2S_CODEC_STAT_EN
    output logic [15:0]             ovr_cnt_o,
    output logic [15:0]             udr_cnt_o,
`endif
    output logic                    busy_o
);

    localparam int LW = DATA_WIDTH;
    localparam int PW = $clog2(LW);

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

    state_t        state;
    logic [2:0]    sync_q [SYNC_STAGES];
    logic          sck_q;
    logic          sck_s, ws_s, sd_s;
    logic          sck_rise, sck_fall;
    logic          ws_cur;
    logic [5:0]    rx_idx, tx_idx;
    logic [5:0]    n_bits;
    logic [LW-1:0] rx_left, rx_right, right_next;
    logic [LW-1:0] tx_left, tx_right, tx_lane;
    logic          frame_edge, boundary, commit, tx_load;
    logic          rx_bit_en, tx_bit;
    logic [PW-1:0] rx_pos, tx_pos;

    // Lane bit that holds wire bit idx of an n-bit sample (left-aligned lanes).
    function automatic logic [PW-1:0] lane_pos(input logic [5:0] idx, input logic [5:0] n,
                                               input logic lsb);
        int p;
        p = lsb ? (LW - int'(n) + int'(idx)) : (LW - 1 - int'(idx));
        return PW'(p);
    endfunction

    function automatic logic [5:0] sat_inc(input logic [5:0] idx);
        return (idx >= 6'd32) ? 6'd32 : idx + 6'd1;
    endfunction

    // ---- synchronizers and SCK edge detect ----
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            sck_q <= 1'b0;
        end else begin
            sync_q[0] <= {sck_i, ws_i, sd_i};
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            sck_q <= sync_q[SYNC_STAGES-1][2];
        end
    end

    assign sck_s    = sync_q[SYNC_STAGES-1][2];
    assign ws_s     = sync_q[SYNC_STAGES-1][1];
    assign sd_s     = sync_q[SYNC_STAGES-1][0];
    assign sck_rise = sck_s & ~sck_q;
    assign sck_fall = ~sck_s & sck_q;

    // ws_s is the new WS sample, ws_cur the one from the previous rising edge.
    assign n_bits     = ({4'd0, dtl_i} + 6'd1) << 3;
    assign boundary   = sck_rise && (ws_s != ws_cur);
    assign frame_edge = sck_rise && ws_cur && !ws_s;
    assign commit     = (state == RIGHT) && frame_edge;
    assign tx_load    = frame_edge && (state != LEFT);
    assign rx_bit_en  = (state != IDLE) && (rx_idx < n_bits);
    assign rx_pos     = lane_pos(rx_idx, n_bits, lsb_i);
    assign tx_pos     = lane_pos(tx_idx, n_bits, lsb_i);
    assign tx_lane    = ws_cur ? tx_right : tx_left;
    assign tx_bit     = (tx_idx < n_bits) ? tx_lane[tx_pos] : 1'b0;
    assign busy_o     = (state != IDLE);

    // The committed right lane must include the bit sampled on the committing edge.
    always_comb begin
        right_next = rx_right;
        if (state == RIGHT && rx_bit_en) right_next[rx_pos] = sd_s;
    end

    // ---- frame FSM, rx deserializer, tx serializer ----
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            rx_idx     <= '0;
            tx_idx     <= '0;
            ws_cur     <= 1'b0;
            sd_o       <= 1'b0;
            rx_valid_o <= 1'b0;
            rx_data_o  <= '0;
            tx_ready_o <= 1'b0;
            ovr_o      <= 1'b0;
            udr_o      <= 1'b0;
        end else begin
            tx_ready_o <= 1'b0;
            ovr_o      <= 1'b0;
            udr_o      <= 1'b0;
            if (sck_rise) ws_cur <= ws_s;
            if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;

            if (!en_i) begin
                state      <= IDLE;
                rx_idx     <= '0;
                tx_idx     <= '0;
                sd_o       <= 1'b0;
                rx_valid_o <= 1'b0;
            end else begin
                if (sck_rise) begin
                    case (state)
                        IDLE: begin
                            if (frame_edge) begin
                                state   <= LEFT;
                                rx_idx  <= '0;
                                tx_idx  <= '0;
                                rx_left <= '0;
                            end
                        end
                        LEFT: begin
                            if (rx_bit_en) rx_left[rx_pos] <= sd_s;
                            if (boundary) begin
                                state    <= RIGHT;
                                rx_idx   <= '0;
                                tx_idx   <= '0;
                                rx_right <= '0;
                            end else begin
                                rx_idx <= sat_inc(rx_idx);
                            end
                        end
                        RIGHT: begin
                            if (rx_bit_en) rx_right[rx_pos] <= sd_s;
                            if (boundary) begin
                                state   <= LEFT;
                                rx_idx  <= '0;
                                tx_idx  <= '0;
                                rx_left <= '0;
                            end else begin
                                rx_idx <= sat_inc(rx_idx);
                            end
                        end
                        default: state <= IDLE;
                    endcase

                    if (tx_load) begin
                        if (tx_valid_i) begin
                            {tx_left, tx_right} <= tx_data_i;
                            tx_ready_o          <= 1'b1;
                        end else begin
                            tx_left  <= '0;
                            tx_right <= '0;
                            udr_o    <= 1'b1;
                        end
                    end

                    if (commit) begin
                        if (!rx_valid_o || rx_ready_i) begin
                            rx_data_o  <= {rx_left, right_next};
                            rx_valid_o <= 1'b1;
                        end else begin
                            ovr_o <= 1'b1;
                        end
                    end
                end

                if (sck_fall && state != IDLE) begin
                    sd_o   <= tx_bit;
                    tx_idx <= sat_inc(tx_idx);
                end
            end
        end
    end

`ifdef I2S_CODEC_STAT_EN
    // ---- saturating event counters ----
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || !en_i) begin
            ovr_cnt_o <= '0;
            udr_cnt_o <= '0;
        end else begin
            if (ovr_o && ovr_cnt_o != 16'hFFFF) ovr_cnt_o <= ovr_cnt_o + 16'd1;
            if (udr_o && udr_cnt_o != 16'hFFFF) udr_cnt_o <= udr_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_codec_ep.sv
// Directed bench for i2s_codec_ep: acts as the I2S master (SCK = clk/16, 32-bit Philips slots).
module tb_i2s_codec_ep;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, lsb;
    logic [1:0]  dtl;
    logic        sck, ws, sd_in;
    logic        sd_out;
    logic        rx_valid, rx_ready;
    logic [63:0] rx_data;
    logic        tx_valid, tx_ready;
    logic [63:0] tx_data;
    logic        ovr, udr, busy;
`ifdef I2S_CODEC_STAT_EN
    logic [15:0] ovr_cnt, udr_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int n_rdy = 0, n_udr = 0, n_ovr = 0, n_rxv = 0, n_sdhi = 0;
    int tx_quota = 0;
    logic rxv_q = 1'b0;

    always #5 clk = ~clk;

    // tx_valid stays up until the endpoint has accepted tx_quota frames in total
    assign tx_valid = (n_rdy < tx_quota);

    i2s_codec_ep dut (
`ifdef I2S_CODEC_STAT_EN
        .ovr_cnt_o  (ovr_cnt),
        .udr_cnt_o  (udr_cnt),
`endif
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .en_i       (en),
        .lsb_i      (lsb),
        .dtl_i      (dtl),
        .sck_i      (sck),
        .ws_i       (ws),
        .sd_i       (sd_in),
        .sd_o       (sd_out),
        .rx_valid_o (rx_valid),
        .rx_ready_i (rx_ready),
        .rx_data_o  (rx_data),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .tx_data_i  (tx_data),
        .ovr_o      (ovr),
        .udr_o      (udr),
        .busy_o     (busy)
    );

    always @(negedge clk) begin
        if (tx_ready) n_rdy <= n_rdy + 1;
        if (udr) n_udr <= n_udr + 1;
        if (ovr) n_ovr <= n_ovr + 1;
        if (rx_valid && !rxv_q) n_rxv <= n_rxv + 1;
        if (sd_out) n_sdhi <= n_sdhi + 1;
        rxv_q <= rx_valid;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One SCK period: WS/SD change at the falling edge, master samples sd_o just before the rise.
    task automatic bit_slot(input logic w, input logic d, output logic c);
        @(negedge clk);
        sck = 1'b0; ws = w; sd_in = d;
        repeat (8) @(negedge clk);
        c = sd_out;
        sck = 1'b1;
        repeat (7) @(negedge clk);
    endtask

    // Words are in wire order: bit 31 is sent first. WS leads the data by one slot.
    task automatic send_frame(input logic [31:0] lw, input logic [31:0] rw,
                              output logic [31:0] cl, output logic [31:0] cr);
        logic b;
        for (int k = 0; k < 32; k++) begin
            bit_slot(k == 31, lw[31-k], b);
            cl[31-k] = b;
        end
        for (int k = 0; k < 32; k++) begin
            bit_slot(k != 31, rw[31-k], b);
            cr[31-k] = b;
        end
    endtask

    task automatic start_stream();
        logic b;
        bit_slot(1'b1, 1'b0, b);
        bit_slot(1'b1, 1'b0, b);
        bit_slot(1'b0, 1'b0, b);
    endtask

    task automatic restart(input logic l, input logic [1:0] d);
        @(negedge clk); en = 1'b0;
        repeat (2) @(negedge clk);
        lsb = l; dtl = d; en = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] cl, cr;
        int r0, u0, s0, o0, v0;

        rst_n = 1'b0; en = 1'b0; lsb = 1'b0; dtl = 2'd1;
        sck = 1'b1; ws = 1'b1; sd_in = 1'b0;
        rx_ready = 1'b0; tx_data = '0;
        repeat (5) @(negedge clk);
        check("rst_sd_o", 64'(sd_out), 64'd0);
        check("rst_rx_valid", 64'(rx_valid), 64'd0);
        check("rst_rx_data", rx_data, 64'd0);
        check("rst_tx_ready", 64'(tx_ready), 64'd0);
        check("rst_ovr", 64'(ovr), 64'd0);
        check("rst_udr", 64'(udr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Rx MSB-first, 16-bit samples, trailing slot bits are garbage to be discarded
        en = 1'b1; lsb = 1'b0; dtl = 2'd1;
        v0 = n_rxv;
        start_stream();
        check("busy_after_start", 64'(busy), 64'd1);
        send_frame(32'hA5C3_FFFF, 32'h1234_ABCD, cl, cr);
        check("rx_msb_data", rx_data, 64'hA5C3_0000_1234_0000);
        check("rx_msb_valid", 64'(rx_valid), 64'd1);
        check("rx_msb_valid_count", 64'(n_rxv - v0), 64'd1);
        @(negedge clk); rx_ready = 1'b1;
        @(negedge clk); rx_ready = 1'b0;
        check("rx_valid_cleared", 64'(rx_valid), 64'd0);

        // Rx LSB-first, 8-bit samples
        restart(1'b1, 2'd0);
        start_stream();
        send_frame(32'h81FF_FFFF, 32'h7E55_AA55, cl, cr);
        check("rx_lsb_sym", rx_data, 64'h8100_0000_7E00_0000);
        @(negedge clk); rx_ready = 1'b1;
        @(negedge clk); rx_ready = 1'b0;
        send_frame(32'h48C0_FFEE, 32'hA312_3456, cl, cr);
        check("rx_lsb_asym", rx_data, 64'h1200_0000_C500_0000);

        // Tx loopback, 32-bit MSB-first; one frame offered
        restart(1'b0, 2'd3);
        rx_ready = 1'b1;
        tx_data = 64'hDEAD_BEEF_0123_4567;
        r0 = n_rdy;
        tx_quota = n_rdy + 1;
        start_stream();
        send_frame(32'h0, 32'h0, cl, cr);
        check("tx_msb_left", 64'(cl), 64'hDEAD_BEEF);
        check("tx_msb_right", 64'(cr), 64'h0123_4567);
        check("tx_ready_count", 64'(n_rdy - r0), 64'd1);

        // Tx LSB-first, 8-bit: slot bits past the sample must be 0
        restart(1'b1, 2'd0);
        tx_data = {32'h12AB_CDEF, 32'hC5FF_FFFF};
        tx_quota = n_rdy + 1;
        start_stream();
        send_frame(32'h0, 32'h0, cl, cr);
        check("tx_lsb_left", 64'(cl), 64'h4800_0000);
        check("tx_lsb_right", 64'(cr), 64'hA300_0000);

        // Overrun: three frames with consumer stalled
        restart(1'b0, 2'd1);
        rx_ready = 1'b0;
        o0 = n_ovr; v0 = n_rxv;
        start_stream();
        send_frame(32'h1111_0000, 32'h2222_0000, cl, cr);
        send_frame(32'h3333_0000, 32'h4444_0000, cl, cr);
        send_frame(32'h5555_0000, 32'h6666_0000, cl, cr);
        check("ovr_data_kept", rx_data, 64'h1111_0000_2222_0000);
        check("ovr_pulses", 64'(n_ovr - o0), 64'd2);
        check("ovr_valid_count", 64'(n_rxv - v0), 64'd1);
`ifdef I2S_CODEC_STAT_EN
        check("ovr_cnt", 64'(ovr_cnt), 64'd2);
`endif
        restart(1'b0, 2'd1);
        check("en_clears_valid", 64'(rx_valid), 64'd0);

        // Underrun: nothing offered; start + two frame commits give three tx loads
        rx_ready = 1'b1;
        tx_quota = n_rdy;
        u0 = n_udr; s0 = n_sdhi; r0 = n_rdy;
        start_stream();
        send_frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, cl, cr);
        send_frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, cl, cr);
        check("udr_pulses", 64'(n_udr - u0), 64'd3);
        check("udr_sd_low", 64'(n_sdhi - s0), 64'd0);
        check("udr_no_ready", 64'(n_rdy - r0), 64'd0);
`ifdef I2S_CODEC_STAT_EN
        check("udr_cnt", 64'(udr_cnt), 64'd3);
`endif

        // Abort mid-LEFT, then a clean frame
        restart(1'b0, 2'd1);
        rx_ready = 1'b0;
        v0 = n_rxv;
        start_stream();
        for (int k = 0; k < 16; k++) bit_slot(1'b0, 1'b1, cl[0]);
        @(negedge clk); en = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_no_valid", 64'(rx_valid), 64'd0);
        check("abort_no_commit", 64'(n_rxv - v0), 64'd0);
        restart(1'b0, 2'd1);
        start_stream();
        send_frame(32'h5A5A_1234, 32'hC3C3_0000, cl, cr);
        check("abort_next_data", rx_data, 64'h5A5A_0000_C3C3_0000);
        check("abort_next_count", 64'(n_rxv - v0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
